// File: rtl/e_stage_muldiv_pkg.sv
// Shared constants for the execute stage: opcodes, func3/func7 encodings and
// the iterative multiply/divide FSM states.
package e_stage_muldiv_pkg;

    localparam int CPU_WIDTH = 64;
    localparam int PC_WIDTH  = 64;
    localparam int REG_WIDTH = 5;
    localparam logic [REG_WIDTH-1:0] RNONE = '0;

    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;

    localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/e_stage_muldiv_iter.sv
// Iterative 1-bit-per-cycle multiply/divide unit: works on operand magnitudes
// and applies the sign fixups to the final product, quotient or remainder.
module muldiv_iter
    import e_stage_muldiv_pkg::*;
#(
    parameter int XLEN = CPU_WIDTH
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    input  logic            hold,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = 7;

    function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext_w(input logic [31:0] v);
        return {{(XLEN-32){1'b0}}, v};
    endfunction

    md_state_t state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        op_q;
    logic              word_q, neg_q, neg_r_q, div0_q;
    logic [XLEN-1:0]   a_ext_q;
    logic [2*XLEN-1:0] prod_q, mcand_q;
    logic [XLEN-1:0]   mplier_q, quo_q, rem_q, dvsr_q;

    logic            is_div, sgn_a, sgn_b, a_neg, b_neg, load, step, q_bit;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
    logic [XLEN:0]   rem_sh, rem_sub;

    always_comb begin
        is_div = op[2];
        sgn_a  = is_div ? ~op[0] : (op == F3_MULH || op == F3_MULHSU);
        sgn_b  = is_div ? ~op[0] : (op == F3_MULH);
        a_ext  = word ? (sgn_a ? sext_w(a[31:0]) : zext_w(a[31:0])) : a;
        b_ext  = word ? (sgn_b ? sext_w(b[31:0]) : zext_w(b[31:0])) : b;
        a_neg  = sgn_a & a_ext[XLEN-1];
        b_neg  = sgn_b & b_ext[XLEN-1];
        a_mag  = a_neg ? -a_ext : a_ext;
        b_mag  = b_neg ? -b_ext : b_ext;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            MD_IDLE: if (start && !flush) begin
                busy    = 1'b1;
                state_d = MD_BUSY;
            end
            MD_BUSY: begin
                busy = 1'b1;
                if (cnt_q == CW'(1)) state_d = MD_DONE;
            end
            MD_DONE: begin
                done = 1'b1;
                if (!hold) state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
        // A flush kills the op from any state, even a held result.
        if (flush) state_d = MD_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= MD_IDLE;
        else       state_q <= state_d;
    end

    assign load = (state_q == MD_IDLE) && start && !flush;
    assign step = (state_q == MD_BUSY);

    // Restoring divide: the dividend shifts out of quo_q's MSB while quotient bits shift in.
    always_comb begin
        rem_sh  = {1'b0, rem_q[XLEN-1:0]} << 1;
        rem_sh[0] = quo_q[XLEN-1];
        rem_sub = rem_sh - {1'b0, dvsr_q};
        q_bit   = ~rem_sub[XLEN];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) cnt_q <= '0;
        else if (load)      cnt_q <= word ? CW'(32) : CW'(XLEN);
        else if (step)      cnt_q <= cnt_q - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q     <= '0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
            div0_q   <= 1'b0;
            a_ext_q  <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
        end else if (load) begin
            op_q     <= op;
            word_q   <= word;
            neg_q    <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            div0_q   <= (b_ext == '0);
            a_ext_q  <= a_ext;
            prod_q   <= '0;
            mcand_q  <= {{XLEN{1'b0}}, b_mag};
            mplier_q <= a_mag;
            // Word dividends sit in the upper half so the MSB-first walk needs only 32 steps.
            quo_q    <= word ? (a_mag << 32) : a_mag;
            rem_q    <= '0;
            dvsr_q   <= b_mag;
        end else if (step) begin
            if (mplier_q[0]) prod_q <= prod_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            rem_q    <= q_bit ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
            quo_q    <= {quo_q[XLEN-2:0], q_bit};
        end
    end

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, res_raw;

    always_comb begin
        prod_s = neg_q ? -prod_q : prod_q;
        quo_s  = div0_q ? '1 : (neg_q ? -quo_q : quo_q);
        rem_s  = div0_q ? a_ext_q : (neg_r_q ? -rem_q : rem_q);
        unique case (op_q)
            F3_MUL:                       res_raw = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: res_raw = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              res_raw = quo_s;
            default:                      res_raw = rem_s;
        endcase
        result = word_q ? sext_w(res_raw[31:0]) : res_raw;
    end

endmodule

// File: rtl/e_stage_muldiv.sv
// RV64IM execute stage: single-cycle ALU, branch unit and jump targets, with
// M-extension ops handed to the iterative muldiv unit that stalls the pipe.
module e_stage_muldiv
    import e_stage_muldiv_pkg::*;
#(
    parameter int XLEN = CPU_WIDTH,
    parameter int PCW  = PC_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [6:0]           E_opcode_i,
    input  logic [2:0]           E_func3_i,
    input  logic [6:0]           E_func7_i,
    input  logic [PCW-1:0]       E_pc_i,
    input  logic [XLEN-1:0]      E_valA_i,
    input  logic [XLEN-1:0]      E_valB_i,
    input  logic [XLEN-1:0]      E_valC_i,
    input  logic [REG_WIDTH-1:0] E_dstE_i,
    input  logic                 E_stall_i,
    input  logic                 e_flush_i,
    output logic [XLEN-1:0]      e_valE_o,
    output logic                 e_cnd_o,
    output logic [PCW-1:0]       e_targetPC_o,
    output logic [REG_WIDTH-1:0] e_dstE_o,
    output logic                 e_busy_o
);
    function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    logic            is_reg, is_w, is_md, alt, br_cnd, md_done;
    logic [5:0]      shamt;
    logic [XLEN-1:0] opb, a_sh, alu_res, md_result;

    always_comb begin
        is_reg = (E_opcode_i == OP) || (E_opcode_i == OP_32);
        is_w   = (E_opcode_i == OP_32) || (E_opcode_i == OP_IMM_32);
        is_md  = is_reg && (E_func7_i == FUNC7_MULDIV);
        opb    = is_reg ? E_valB_i : E_valC_i;
        alt    = E_func7_i[5];
        shamt  = is_w ? {1'b0, opb[4:0]} : opb[5:0];
        a_sh   = E_valA_i;
        if (is_w) a_sh = alt ? sext_w(E_valA_i[31:0]) : {{(XLEN-32){1'b0}}, E_valA_i[31:0]};
        unique case (E_func3_i)
            3'b000:  alu_res = (is_reg && alt) ? E_valA_i - opb : E_valA_i + opb;
            3'b001:  alu_res = E_valA_i << shamt;
            3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(E_valA_i) < $signed(opb)};
            3'b011:  alu_res = {{(XLEN-1){1'b0}}, E_valA_i < opb};
            3'b100:  alu_res = E_valA_i ^ opb;
            3'b101:  alu_res = alt ? XLEN'($signed(a_sh) >>> shamt) : a_sh >> shamt;
            3'b110:  alu_res = E_valA_i | opb;
            default: alu_res = E_valA_i & opb;
        endcase
        if (is_w) alu_res = sext_w(alu_res[31:0]);
    end

    always_comb begin
        unique case (E_func3_i)
            F3_BEQ:  br_cnd = (E_valA_i == E_valB_i);
            F3_BNE:  br_cnd = (E_valA_i != E_valB_i);
            F3_BLT:  br_cnd = ($signed(E_valA_i) <  $signed(E_valB_i));
            F3_BGE:  br_cnd = ($signed(E_valA_i) >= $signed(E_valB_i));
            F3_BLTU: br_cnd = (E_valA_i <  E_valB_i);
            F3_BGEU: br_cnd = (E_valA_i >= E_valB_i);
            default: br_cnd = 1'b0;
        endcase
    end

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start  (is_md),
        .op     (E_func3_i),
        .word   (E_opcode_i == OP_32),
        .a      (E_valA_i),
        .b      (E_valB_i),
        .flush  (e_flush_i),
        .hold   (E_stall_i),
        .busy   (e_busy_o),
        .done   (md_done),
        .result (md_result)
    );

    always_comb begin
        e_valE_o     = '0;
        e_cnd_o      = 1'b0;
        e_targetPC_o = '0;
        case (E_opcode_i)
            OP, OP_32:         e_valE_o = is_md ? (md_done ? md_result : '0) : alu_res;
            OP_IMM, OP_IMM_32: e_valE_o = alu_res;
            LUI:               e_valE_o = E_valC_i;
            AUIPC:             e_valE_o = XLEN'(E_pc_i) + E_valC_i;
            JAL: begin
                e_valE_o     = XLEN'(E_pc_i) + XLEN'(4);
                e_cnd_o      = 1'b1;
                e_targetPC_o = E_pc_i + PCW'(E_valC_i);
            end
            JALR: begin
                e_valE_o     = XLEN'(E_pc_i) + XLEN'(4);
                e_cnd_o      = 1'b1;
                e_targetPC_o = PCW'(E_valA_i + E_valC_i) & ~PCW'(1);
            end
            BRANCH: begin
                e_cnd_o      = br_cnd;
                e_targetPC_o = E_pc_i + PCW'(E_valC_i);
            end
            LOAD, STORE:       e_valE_o = E_valA_i + E_valC_i;
            default:           e_valE_o = '0;
        endcase
    end

    assign e_dstE_o = e_busy_o ? RNONE : E_dstE_i;

endmodule

// File: tb/tb_e_stage_muldiv.sv
// Directed bench for e_stage_muldiv with a result scoreboard queue.
module tb_e_stage_muldiv;
    import e_stage_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [63:0] pc, va, vb, vc, vale, tgt;
    logic [4:0]  dst_in, dst_out;
    logic        stall, flush, cnd, busy;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    e_stage_muldiv dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .E_opcode_i   (opc),
        .E_func3_i    (f3),
        .E_func7_i    (f7),
        .E_pc_i       (pc),
        .E_valA_i     (va),
        .E_valB_i     (vb),
        .E_valC_i     (vc),
        .E_dstE_i     (dst_in),
        .E_stall_i    (stall),
        .e_flush_i    (flush),
        .e_valE_o     (vale),
        .e_cnd_o      (cnd),
        .e_targetPC_o (tgt),
        .e_dstE_o     (dst_out),
        .e_busy_o     (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] o, input logic [2:0] fn3, input logic [6:0] fn7,
                         input logic [63:0] p, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [4:0] d);
        opc = o; f3 = fn3; f7 = fn7; pc = p; va = a; vb = b; vc = c; dst_in = d;
    endtask

    task automatic bubble();
        drive(7'd0, 3'd0, 7'd0, 64'd0, 64'd0, 64'd0, 64'd0, RNONE);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input string tag, input logic [6:0] o, input logic [2:0] fn3,
                          input logic [6:0] fn7, input logic [63:0] p, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] c, input logic [63:0] exp);
        drive(o, fn3, fn7, p, a, b, c, 5'd3);
        sb.push_back(exp);
        @(negedge clk);
        check(tag, vale, sb.pop_front());
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        tick();
    endtask

    task automatic branch_op(input string tag, input logic [6:0] o, input logic [2:0] fn3,
                             input logic [63:0] p, input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] c, input logic exp_cnd, input logic [63:0] exp_tgt);
        drive(o, fn3, 7'd0, p, a, b, c, 5'd1);
        @(negedge clk);
        check({tag, "_cnd"}, {63'd0, cnd}, {63'd0, exp_cnd});
        check({tag, "_tgt"}, tgt, exp_tgt);
        tick();
    endtask

    // Starts an M op, counts busy cycles, checks the result in the DONE cycle.
    task automatic md_op(input string tag, input logic [6:0] o, input logic [2:0] fn3,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                         input int ncyc, input bit leave);
        int n;
        drive(o, fn3, FUNC7_MULDIV, 64'd0, a, b, 64'd0, 5'd9);
        sb.push_back(exp);
        n = 0;
        @(negedge clk);
        check({tag, "_dst_busy"}, {59'd0, dst_out}, {59'd0, RNONE});
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_cycles"}, 64'(n), 64'(ncyc));
        check(tag, vale, sb.pop_front());
        check({tag, "_dst"}, {59'd0, dst_out}, 64'd9);
        if (leave) begin
            bubble();
            tick();
        end
    endtask

    initial begin
        rst_i = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        bubble();
        tick();
        tick();
        @(negedge clk);
        check("rst_valE", vale, 64'd0);
        check("rst_cnd", {63'd0, cnd}, 64'd0);
        check("rst_tgt", tgt, 64'd0);
        check("rst_dst", {59'd0, dst_out}, {59'd0, RNONE});
        check("rst_busy", {63'd0, busy}, 64'd0);
        tick();
        rst_i = 1'b0;
        tick();

        alu_op("add", OP, 3'b000, 7'd0, 64'd0, 64'd5, -64'sd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE);
        alu_op("srai", OP_IMM, 3'b101, 7'b0100000, 64'd0, 64'hFFFF_FFFF_FFFF_FF00, 64'd0,
               64'd36, 64'hFFFF_FFFF_FFFF_FFFF);
        alu_op("sraw", OP_32, 3'b101, 7'b0100000, 64'd0, 64'h0000_0000_8000_0000, 64'd4,
               64'd0, 64'hFFFF_FFFF_F800_0000);
        alu_op("lui", LUI, 3'b000, 7'd0, 64'd0, 64'd0, 64'd0, 64'h1234_5000, 64'h1234_5000);
        alu_op("auipc", AUIPC, 3'b000, 7'd0, 64'h1000, 64'd0, 64'd0, 64'h10, 64'h1010);
        alu_op("load", LOAD, 3'b011, 7'd0, 64'd0, 64'h100, 64'd0, -64'sd8, 64'hF8);
        alu_op("jalr_link", JALR, 3'b000, 7'd0, 64'h200, 64'h1001, 64'd0, 64'h2, 64'h204);

        branch_op("blt", BRANCH, F3_BLT, 64'h100, -64'sd1, 64'd1, 64'h20, 1'b1, 64'h120);
        branch_op("bltu", BRANCH, F3_BLTU, 64'h100, -64'sd1, 64'd1, 64'h20, 1'b0, 64'h120);
        branch_op("jalr", JALR, 3'b000, 64'h200, 64'h1001, 64'd0, 64'h2, 1'b1, 64'h1002);

        md_op("mulh", OP, F3_MULH, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1);
        md_op("mul", OP, F3_MUL, 64'h8000_0000_0000_0000, 64'd2, 64'd0, 65, 1);
        md_op("mulhu", OP, F3_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFE, 65, 1);
        md_op("div0", OP, F3_DIV, 64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1);
        md_op("rem0", OP, F3_REM, 64'd42, 64'd0, 64'd42, 65, 1);
        md_op("div_ovf", OP, F3_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 65, 1);

        // DIVW result held in DONE while the E register is stalled.
        md_op("divw", OP_32, F3_DIV, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("hold_valE", vale, 64'hFFFF_FFFF_FFFF_FFFD);
            check("hold_busy", {63'd0, busy}, 64'd0);
        end
        stall = 1'b0;
        bubble();
        tick();

        // Flush at BUSY cycle 10.
        drive(OP, F3_DIVU, FUNC7_MULDIV, 64'd0, 64'd100, 64'd7, 64'd0, 5'd9);
        repeat (10) tick();
        flush = 1'b1;
        bubble();
        @(negedge clk);
        check("flush_busy_same", {63'd0, busy}, 64'd1);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy_after", {63'd0, busy}, 64'd0);
        tick();

        // Reset mid-BUSY.
        drive(OP, F3_DIVU, FUNC7_MULDIV, 64'd0, 64'd100, 64'd7, 64'd0, 5'd9);
        repeat (5) tick();
        @(negedge clk);
        check("rst_mid_busy_before", {63'd0, busy}, 64'd1);
        tick();
        rst_i = 1'b1;
        bubble();
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_mid_busy_after", {63'd0, busy}, 64'd0);
        tick();

        md_op("remw", OP_32, F3_REM, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, 1);
        md_op("divu", OP, F3_DIVU, 64'd100, 64'd7, 64'd14, 65, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
